// File: rtl/hex_debug_pager_pkg.sv
// Shared constants, index-update codes and the channel wrap helper for the hex debug pager.
package hex_debug_pager_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [2:0] {
        UPD_NONE,
        UPD_DIRECT,
        UPD_NEXT,
        UPD_PREV,
        UPD_AUTO
    } upd_e;

    // Step a channel index one place up or down, wrapping inside 0..n-1.
    function automatic int unsigned wrap_step(int unsigned idx, int unsigned n, bit up);
        if (up) begin
            return (idx == n - 1) ? 0 : idx + 1;
        end
        return (idx == 0) ? n - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/hex_debug_pager_if.sv
// Pager bus: debug source, raw keys and mode levels in; segments and status out.
interface hex_debug_pager_if #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 32,
    parameter int NUM_DIGITS = 6,
    parameter int IDX_W      = $clog2(NUM_CH)
);
    logic [NUM_CH*CH_W-1:0]  debug;
    logic                    btn_next_n;
    logic                    btn_prev_n;
    logic                    btn_hold_n;
    logic                    auto_en;
    logic                    direct_en;
    logic [IDX_W-1:0]        direct_sel;
    logic [NUM_DIGITS*7-1:0] hex;
    logic [IDX_W-1:0]        ch_idx;
    logic                    hold_active;

    modport master (
        output debug, btn_next_n, btn_prev_n, btn_hold_n, auto_en, direct_en, direct_sel,
        input  hex, ch_idx, hold_active
    );

    modport slave (
        input  debug, btn_next_n, btn_prev_n, btn_hold_n, auto_en, direct_en, direct_sel,
        output hex, ch_idx, hold_active
    );
endinterface

// File: rtl/hex_debug_pager_btn_debounce.sv
// Raw active-low key -> synchronised, debounced, one-cycle press pulse on the 1->0 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press_pulse
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             done;

    assign differ      = (sync2 != level);
    assign done        = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press_pulse = done && !sync2;

    // level comes out of reset as "pressed" so a key held through reset must be seen
    // released before it can produce a press; a released key settles silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            if (!differ) begin
                cnt <= '0;
            end else if (done) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/hex_decoder.sv
// Nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_decoder
    import hex_debug_pager_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_ZERO;
        case (nibble)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/hex_debug_pager.sv
// Pages NUM_CH debug channels onto NUM_DIGITS hex digits via keys, direct select or auto-scroll,
// with a hold mode that freezes a snapshot of the whole bus.
module hex_debug_pager
    import hex_debug_pager_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CH_W            = 32,
    parameter int NUM_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input logic               clk,
    input logic               rst_n,
    hex_debug_pager_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int TMR_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int NIBS  = CH_W / 4;

    logic                   next_p;
    logic                   prev_p;
    logic                   hold_p;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       idx_inc, idx_dec, idx_dir;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   tmr_done;
    logic                   hold_q;
    logic [NUM_CH*CH_W-1:0] snap_q;
    logic [NUM_CH*CH_W-1:0] src_bus;
    logic [CH_W-1:0]        disp_q;
    upd_e                   upd;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_next_n), .press_pulse(next_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_prev_n), .press_pulse(prev_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_hold_n), .press_pulse(hold_p));

    assign idx_inc  = IDX_W'(wrap_step(32'(idx_q), NUM_CH, 1'b1));
    assign idx_dec  = IDX_W'(wrap_step(32'(idx_q), NUM_CH, 1'b0));
    assign idx_dir  = (32'(bus.direct_sel) >= 32'(NUM_CH)) ? IDX_W'(NUM_CH - 1) : bus.direct_sel;
    assign tmr_done = (tmr_q == TMR_W'(AUTO_PERIOD - 1));
    assign src_bus  = hold_q ? snap_q : bus.debug;

    always_comb begin
        upd   = UPD_NONE;
        idx_d = idx_q;
        tmr_d = tmr_q + TMR_W'(1);
        if (bus.direct_en)            upd = UPD_DIRECT;
        else if (next_p && prev_p)    upd = UPD_NONE;
        else if (next_p)              upd = UPD_NEXT;
        else if (prev_p)              upd = UPD_PREV;
        else if (bus.auto_en && tmr_done) upd = UPD_AUTO;
        case (upd)
            UPD_DIRECT:         idx_d = idx_dir;
            UPD_NEXT, UPD_AUTO: idx_d = idx_inc;
            UPD_PREV:           idx_d = idx_dec;
            default:            idx_d = idx_q;
        endcase
        // Manual paging restarts the full auto period.
        if (bus.direct_en || !bus.auto_en || next_p || prev_p || upd == UPD_AUTO) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            tmr_q  <= '0;
            hold_q <= 1'b0;
            snap_q <= '0;
            disp_q <= '0;
        end else begin
            idx_q  <= idx_d;
            tmr_q  <= tmr_d;
            disp_q <= src_bus[idx_q*CH_W +: CH_W];
            if (hold_p) begin
                if (!hold_q) begin
                    snap_q <= bus.debug;
                    hold_q <= 1'b1;
                end else begin
                    hold_q <= 1'b0;
                end
            end
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        if (d < NIBS) begin : g_show
            logic [6:0] seg;
            hex_decoder u_dec (.nibble(disp_q[4*d +: 4]), .seg(seg));
            assign bus.hex[d*7 +: 7] = seg;
        end else begin : g_blank
            assign bus.hex[d*7 +: 7] = SEG_BLANK;
        end
    end

    assign bus.ch_idx      = idx_q;
    assign bus.hold_active = hold_q;
endmodule

// File: tb/tb_hex_debug_pager.sv
// Random and scenario stimulus for hex_debug_pager, checked against a behavioural model via a scoreboard.
module tb_hex_debug_pager;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 32;
    localparam int NUM_DIGITS = 6;
    localparam int DC         = 4;
    localparam int AP         = 16;
    localparam int IDX_W      = 2;
    localparam int HEX_W      = NUM_DIGITS * 7;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             hold;
        logic [HEX_W-1:0] hex;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    hex_debug_pager_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_DIGITS(NUM_DIGITS)) bus ();

    hex_debug_pager #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_DIGITS(NUM_DIGITS),
        .DEBOUNCE_CYCLES(DC), .AUTO_PERIOD(AP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [HEX_W-1:0] hex_of(input logic [CH_W-1:0] v);
        logic [HEX_W-1:0] h;
        h = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            h[d*7 +: 7] = (d < CH_W / 4) ? SEG_TAB[v[d*4 +: 4]] : 7'h7F;
        end
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int                     m_idx;
    int                     m_timer;
    bit                     m_hold;
    logic [NUM_CH*CH_W-1:0] m_snap;
    logic [CH_W-1:0]        m_disp;
    bit                     hist[3][$];
    bit                     lvl[3];
    bit                     pulse[3];

    task automatic model_reset();
        m_idx   = 0;
        m_timer = 0;
        m_hold  = 0;
        m_snap  = '0;
        m_disp  = '0;
        for (int b = 0; b < 3; b++) begin
            // No evidence before reset, then the two synchroniser stages holding "released".
            hist[b].delete();
            repeat (DC) hist[b].push_back(1'b0);
            repeat (2) hist[b].push_back(1'b1);
            lvl[b] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        bit                     raw[3];
        bit                     stable;
        bit                     auto_step;
        logic [NUM_CH*CH_W-1:0] src;
        exp_t                   e;
        raw[0] = bus.btn_next_n;
        raw[1] = bus.btn_prev_n;
        raw[2] = bus.btn_hold_n;
        for (int b = 0; b < 3; b++) begin
            hist[b].push_back(raw[b]);
            if (hist[b].size() > DC + 2) void'(hist[b].pop_front());
            // The oldest DC entries are the samples that have crossed both synchroniser stages.
            stable = 1'b1;
            for (int k = 0; k < DC; k++) if (hist[b][k] == lvl[b]) stable = 1'b0;
            pulse[b] = 1'b0;
            if (stable) begin
                lvl[b]   = !lvl[b];
                pulse[b] = !lvl[b];
            end
        end
        src    = m_hold ? m_snap : bus.debug;
        m_disp = src[m_idx*CH_W +: CH_W];
        if (bus.direct_en) begin
            m_idx   = (int'(bus.direct_sel) >= NUM_CH) ? NUM_CH - 1 : int'(bus.direct_sel);
            m_timer = 0;
        end else begin
            auto_step = bus.auto_en && (m_timer == AP - 1);
            if (pulse[0] && pulse[1]) m_idx = m_idx;
            else if (pulse[0])        m_idx = (m_idx + 1) % NUM_CH;
            else if (pulse[1])        m_idx = (m_idx + NUM_CH - 1) % NUM_CH;
            else if (auto_step)       m_idx = (m_idx + 1) % NUM_CH;
            if (!bus.auto_en || pulse[0] || pulse[1] || auto_step) m_timer = 0;
            else m_timer = m_timer + 1;
        end
        if (pulse[2]) begin
            if (!m_hold) begin
                m_snap = bus.debug;
                m_hold = 1'b1;
            end else begin
                m_hold = 1'b0;
            end
        end
        e.idx  = IDX_W'(m_idx);
        e.hold = m_hold;
        e.hex  = hex_of(m_disp);
        exp_q.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            check("rst_ch_idx", 64'(bus.ch_idx), 64'd0);
            check("rst_hold", 64'(bus.hold_active), 64'd0);
            check("rst_hex", 64'(bus.hex), 64'(hex_of('0)));
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ch_idx", 64'(bus.ch_idx), 64'(e.idx));
            check("hold_active", 64'(bus.hold_active), 64'(e.hold));
            check("hex", 64'(bus.hex), 64'(e.hex));
        end
    end

    // ---------------- driver ----------------
    task automatic set_btns(input int mask, input bit val);
        if (mask[0]) bus.btn_next_n = val;
        if (mask[1]) bus.btn_prev_n = val;
        if (mask[2]) bus.btn_hold_n = val;
    endtask

    task automatic press(input int mask, input int lo, input int hi);
        @(negedge clk);
        set_btns(mask, 1'b0);
        repeat (lo) @(negedge clk);
        set_btns(mask, 1'b1);
        repeat (hi) @(negedge clk);
    endtask

    bit btn_state[3];
    int cd[3];

    initial begin
        bus.btn_next_n = 1'b1;
        bus.btn_prev_n = 1'b1;
        bus.btn_hold_n = 1'b1;
        bus.auto_en    = 1'b0;
        bus.direct_en  = 1'b0;
        bus.direct_sel = '0;
        bus.debug      = {$urandom(), $urandom(), $urandom(), 32'h00ABCDEF};
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_hex", 64'(bus.hex), 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
        check("first_idx", 64'(bus.ch_idx), 64'd0);
        repeat (8) @(negedge clk);

        // short glitch then a full press with exact latency
        press(1, 2, 8);
        check("glitch_idx", 64'(bus.ch_idx), 64'd0);
        @(negedge clk);
        bus.btn_next_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("lat_before", 64'(bus.ch_idx), 64'd0);
        @(posedge clk);
        #1 check("lat_after", 64'(bus.ch_idx), 64'd1);
        repeat (4) @(negedge clk);
        bus.btn_next_n = 1'b1;
        repeat (8) @(negedge clk);

        press(1, 8, 8);
        press(1, 8, 8);
        check("idx_three", 64'(bus.ch_idx), 64'd3);
        press(1, 8, 8);
        check("wrap_zero", 64'(bus.ch_idx), 64'd0);
        press(1, 8, 8);
        press(1, 8, 8);
        press(1, 8, 8);
        check("back_three", 64'(bus.ch_idx), 64'd3);
        press(3, 8, 8);
        check("both_keys", 64'(bus.ch_idx), 64'd3);
        press(1, 8, 8);
        press(2, 8, 8);
        check("prev_wrap", 64'(bus.ch_idx), 64'd3);

        // auto-scroll, with a manual press in the middle of a period
        @(negedge clk);
        bus.auto_en = 1'b1;
        repeat (26) @(negedge clk);
        press(1, 6, 40);
        bus.auto_en = 1'b0;

        // hold freezes the bus; paging browses the snapshot
        @(negedge clk);
        bus.direct_en  = 1'b1;
        bus.direct_sel = 2'd1;
        bus.debug[CH_W +: CH_W] = 32'h1111;
        @(negedge clk);
        bus.direct_en = 1'b0;
        repeat (2) @(negedge clk);
        press(4, 8, 8);
        bus.debug[CH_W +: CH_W] = 32'h2222;
        repeat (3) @(negedge clk);
        check("hold_flag", 64'(bus.hold_active), 64'd1);
        check("hold_hex", 64'(bus.hex), 64'({7'h40, 7'h40, 7'h79, 7'h79, 7'h79, 7'h79}));
        press(1, 8, 8);
        press(4, 8, 8);
        press(2, 8, 8);

        // direct select overrides keys
        @(negedge clk);
        bus.direct_en  = 1'b1;
        bus.direct_sel = 2'd2;
        press(1, 8, 8);
        check("direct_idx", 64'(bus.ch_idx), 64'd2);
        bus.direct_en = 1'b0;

        // randomized traffic
        for (int b = 0; b < 3; b++) begin
            btn_state[b] = 1'b1;
            cd[b] = $urandom_range(1, 12);
        end
        repeat (700) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (cd[b] == 0) begin
                    btn_state[b] = !btn_state[b];
                    set_btns(1 << b, btn_state[b]);
                    cd[b] = $urandom_range(1, 12);
                end else begin
                    cd[b]--;
                end
            end
            if ($urandom_range(0, 9) == 0) bus.debug[$urandom_range(0, NUM_CH - 1)*CH_W +: CH_W] = $urandom();
            if ($urandom_range(0, 49) == 0) bus.auto_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                bus.direct_en  = ($urandom_range(0, 3) == 0);
                bus.direct_sel = IDX_W'($urandom_range(0, NUM_CH - 1));
            end
        end
        set_btns(7, 1'b1);
        bus.direct_en = 1'b0;
        bus.auto_en   = 1'b1;
        repeat (40) @(negedge clk);

        // reset mid-auto-scroll with the next key held through it
        @(posedge clk);
        #3;
        rst_n          = 1'b0;
        bus.auto_en    = 1'b0;
        bus.btn_next_n = 1'b0;
        #1;
        check("async_idx", 64'(bus.ch_idx), 64'd0);
        check("async_hold", 64'(bus.hold_active), 64'd0);
        check("async_hex", 64'(bus.hex), 64'(hex_of('0)));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_thru_rst", 64'(bus.ch_idx), 64'd0);
        bus.btn_next_n = 1'b1;
        repeat (8) @(negedge clk);
        press(1, 8, 8);
        check("press_after_rst", 64'(bus.ch_idx), 64'd1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
